// File: rtl/modport_source_driver_pkg.sv
// Shared lane types and elaboration-time index helpers for the source/sink lane bus.
package modport_lane_pkg;

   localparam int unsigned LANE_W = 1;

   typedef logic [LANE_W-1:0] lane_t;

   // Index of the derived (top) lane for an n-lane bus.
   function automatic int unsigned top_lane(input int unsigned n);
      return n - 1;
   endfunction

endpackage

// File: rtl/modport_source_driver_if.sv
// One-bit lane: producers attach via the source modport, consumers via sink.
interface lane_if;
   import modport_lane_pkg::*;

   lane_t logic_in_intf;

   modport source (output logic_in_intf);
   modport sink   (input  logic_in_intf);

endinterface

// File: rtl/modport_source_driver_lane_reg.sv
// Single lane register driving its lane through the source modport.
module lane_reg
   import modport_lane_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  lane_t        d,
   lane_if.source       q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q.logic_in_intf <= '0;
      end else if (en) begin
         q.logic_in_intf <= d;
      end
   end

endmodule

// File: rtl/modport_source_driver.sv
// Drives N lanes from data_in; the top lane is optionally the inverse of the lane below.
module modport_source_driver
   import modport_lane_pkg::*;
#(
   parameter int unsigned N       = 6,
   parameter bit          INV_TOP = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] data_in,
   output logic [N-1:0] lane_out,
   output logic         lane_ok
);

   localparam int unsigned TOP = top_lane(N);

   logic [N-1:0] d_vec;
   logic         top_d;

   // Derived lane is taken from the input so both top lanes move on the same edge.
   assign top_d = INV_TOP ? ~data_in[TOP-1] : data_in[TOP];

   always_comb begin
      d_vec      = data_in;
      d_vec[TOP] = top_d;
   end

   lane_if lanes [N] ();

   for (genvar i = 0; i < N; i++) begin : g_lane
      lane_reg u_lane_reg (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .d   (lane_t'(d_vec[i])),
         .q   (lanes[i])
      );
      assign lane_out[i] = lanes[i].logic_in_intf;
   end

   // Consistency of the derived lane, evaluated on the values being loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_ok <= 1'b1;
      end else if (en) begin
         lane_ok <= INV_TOP ? (d_vec[TOP] == ~d_vec[TOP-1]) : 1'b1;
      end
   end

endmodule

// File: tb/tb_modport_source_driver.sv
// Directed bench for modport_source_driver with both INV_TOP settings side by side.
module tb_modport_source_driver;
   import modport_lane_pkg::*;

   localparam int unsigned N    = 6;
   localparam int unsigned LIDX = top_lane(N) - 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [N-1:0] data_in;
   logic [N-1:0] lane_out_inv, lane_out_pass;
   logic         lane_ok_inv, lane_ok_pass;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   modport_source_driver #(.N(N), .INV_TOP(1'b1)) dut_inv (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .data_in  (data_in),
      .lane_out (lane_out_inv),
      .lane_ok  (lane_ok_inv)
   );

   modport_source_driver #(.N(N), .INV_TOP(1'b0)) dut_pass (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .data_in  (data_in),
      .lane_out (lane_out_pass),
      .lane_ok  (lane_ok_pass)
   );

   lane_if mon [N] ();
   for (genvar i = 0; i < N; i++) begin : g_mon
      assign mon[i].logic_in_intf = lane_out_inv[i];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; data_in = '0;
      #1;
      step(); step();
      check("rst_lane_inv",  32'(lane_out_inv),  32'h00);
      check("rst_ok_inv",    32'(lane_ok_inv),   32'h1);
      check("rst_lane_pass", 32'(lane_out_pass), 32'h00);
      check("rst_ok_pass",   32'(lane_ok_pass),  32'h1);

      rst = 1'b0; en = 1'b1; data_in = 6'b010101;
      step();
      check("ld1_lane_inv",  32'(lane_out_inv),  32'b010101);
      check("ld1_top_inv",   32'(lane_out_inv[5]), 32'h0);
      check("ld1_ok_inv",    32'(lane_ok_inv),   32'h1);
      check("ld1_lane_pass", 32'(lane_out_pass), 32'b010101);

      data_in = 6'b101010;
      step();
      check("ld2_lane_inv",  32'(lane_out_inv),  32'b101010);
      check("ld2_lane3",     32'(mon[LIDX].logic_in_intf), 32'h1);
      check("ld2_ok_inv",    32'(lane_ok_inv),   32'h1);
      check("ld2_lane_pass", 32'(lane_out_pass), 32'b101010);

      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_in = ~data_in;
         step();
         check("hold_lane_inv",  32'(lane_out_inv),  32'b101010);
         check("hold_ok_inv",    32'(lane_ok_inv),   32'h1);
         check("hold_lane_pass", 32'(lane_out_pass), 32'b101010);
      end

      rst = 1'b1; en = 1'b1; data_in = 6'b111111;
      step();
      check("rst_en_lane_inv",  32'(lane_out_inv),  32'h00);
      check("rst_en_ok_inv",    32'(lane_ok_inv),   32'h1);
      check("rst_en_lane_pass", 32'(lane_out_pass), 32'h00);

      rst = 1'b0; en = 1'b1; data_in = 6'b110000;
      step();
      check("ld3_lane_pass", 32'(lane_out_pass), 32'b110000);
      check("ld3_lane_inv",  32'(lane_out_inv),  32'b010000);
      check("ld3_ok_inv",    32'(lane_ok_inv),   32'h1);
      check("ld3_ok_pass",   32'(lane_ok_pass),  32'h1);

      data_in = 6'b000000;
      step();
      check("ld4_lane_inv",  32'(lane_out_inv),  32'b100000);
      check("ld4_lane_pass", 32'(lane_out_pass), 32'b000000);

      data_in = 6'b011111;
      step();
      check("ld5_lane_inv",  32'(lane_out_inv),  32'b011111);
      check("ld5_lane_pass", 32'(lane_out_pass), 32'b011111);

      en = 1'b0; data_in = 6'b100000;
      step();
      check("hold2_lane_inv",  32'(lane_out_inv),  32'b011111);
      check("hold2_lane_pass", 32'(lane_out_pass), 32'b011111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
